// File: rtl/ram_pipe.sv
// ram_pipe: dual-port word RAM with an instruction read port and a data
// read/write port. Each port is a one-deep valid/ready pipeline with a fixed
// one-cycle response latency and registered response data. A data write and
// an instruction read to the same word on the same edge give the instruction
// port the merged (write-first) word.
module ram_pipe #(
  parameter int DATA_WIDTH = 32,  // 32 or 64
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst_n,
  // instruction port
  input  logic                    i_inst_req_valid,
  output logic                    o_inst_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_inst_req_addr,
  output logic                    o_inst_resp_valid,
  input  logic                    i_inst_resp_ready,
  output logic [DATA_WIDTH-1:0]   o_inst_resp_data,
  output logic                    o_inst_resp_err,
  // data port
  input  logic                    i_data_req_valid,
  output logic                    o_data_req_ready,
  input  logic                    i_data_req_wen,
  input  logic [ADDR_WIDTH-1:0]   i_data_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_data_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_data_req_mask,
  output logic                    o_data_resp_valid,
  input  logic                    i_data_resp_ready,
  output logic [DATA_WIDTH-1:0]   o_data_resp_rdata,
  output logic                    o_data_resp_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TOP   = DEPTH_LOG2 + OFF;  // first address bit above the array

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  // Word storage; never reset so contents survive a reset pulse.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // An address is usable only if word aligned and inside the array.
  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    logic misaligned;
    logic out_of_range;
    misaligned   = |(a & ADDR_WIDTH'((1 << OFF) - 1));
    out_of_range = |(a >> TOP);
    return misaligned | out_of_range;
  endfunction

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  state_e                inst_state_q, inst_state_d;
  state_e                data_state_q, data_state_d;
  logic [DATA_WIDTH-1:0] inst_data_q,  inst_data_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  inst_err_q,   inst_err_d;
  logic                  data_err_q,   data_err_d;

  logic                  inst_acc;
  logic                  data_acc;
  logic                  inst_req_err;
  logic                  data_req_err;
  logic [DEPTH_LOG2-1:0] inst_idx;
  logic [DEPTH_LOG2-1:0] data_idx;
  logic                  wr_en;
  logic                  same_word;
  logic [BYTES-1:0]      byte_we;
  logic [DATA_WIDTH-1:0] inst_rd_word;
  logic [DATA_WIDTH-1:0] inst_merged;
  logic [DATA_WIDTH-1:0] data_rd_word;

  assign o_inst_resp_valid = (inst_state_q == S_RESP);
  assign o_data_resp_valid = (data_state_q == S_RESP);

  // A port can take a new request whenever its response slot is empty or
  // being drained this cycle.
  assign o_inst_req_ready = !o_inst_resp_valid || i_inst_resp_ready;
  assign o_data_req_ready = !o_data_resp_valid || i_data_resp_ready;

  assign inst_acc = i_inst_req_valid && o_inst_req_ready;
  assign data_acc = i_data_req_valid && o_data_req_ready;

  assign inst_req_err = addr_bad(i_inst_req_addr);
  assign data_req_err = addr_bad(i_data_req_addr);

  assign inst_idx = i_inst_req_addr[TOP-1:OFF];
  assign data_idx = i_data_req_addr[TOP-1:OFF];

  // Reset level also gates the write so nothing lands in storage while held.
  assign wr_en     = i_sys_rst_n && data_acc && i_data_req_wen && !data_req_err;
  assign same_word = (inst_idx == data_idx);

  assign inst_rd_word = mem[inst_idx];
  assign data_rd_word = mem[data_idx];

  // Per-lane write enables and write-first bypass for the instruction port.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign byte_we[gi] = wr_en && i_data_req_mask[gi];
      assign inst_merged[8*gi +: 8] = (byte_we[gi] && same_word) ?
                                      i_data_req_wdata[8*gi +: 8] :
                                      inst_rd_word[8*gi +: 8];
    end
  endgenerate

  // Byte-lane masked write into storage.
  always_ff @(posedge i_sys_clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (byte_we[b]) begin
        mem[data_idx][8*b +: 8] <= i_data_req_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Instruction port response FSM
  // ---------------------------------------------------------------------

  // Next state and response capture for the instruction port.
  always_comb begin
    inst_state_d = inst_state_q;
    inst_data_d  = inst_data_q;
    inst_err_d   = inst_err_q;
    case (inst_state_q)
      S_IDLE: begin
        if (inst_acc) begin
          inst_state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (inst_acc) begin
          inst_state_d = S_RESP;
        end else if (i_inst_resp_ready) begin
          inst_state_d = S_IDLE;
        end
      end
      default: inst_state_d = S_IDLE;
    endcase
    if (inst_acc) begin
      inst_err_d  = inst_req_err;
      inst_data_d = inst_req_err ? '0 : inst_merged;
    end
  end

  // Instruction port state and response registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      inst_state_q <= S_IDLE;
      inst_data_q  <= '0;
      inst_err_q   <= 1'b0;
    end else begin
      inst_state_q <= inst_state_d;
      inst_data_q  <= inst_data_d;
      inst_err_q   <= inst_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Data port response FSM
  // ---------------------------------------------------------------------

  // Next state and response capture for the data port; writes answer zero.
  always_comb begin
    data_state_d = data_state_q;
    data_rdata_d = data_rdata_q;
    data_err_d   = data_err_q;
    case (data_state_q)
      S_IDLE: begin
        if (data_acc) begin
          data_state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (data_acc) begin
          data_state_d = S_RESP;
        end else if (i_data_resp_ready) begin
          data_state_d = S_IDLE;
        end
      end
      default: data_state_d = S_IDLE;
    endcase
    if (data_acc) begin
      data_err_d   = data_req_err;
      data_rdata_d = (data_req_err || i_data_req_wen) ? '0 : data_rd_word;
    end
  end

  // Data port state and response registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      data_state_q <= S_IDLE;
      data_rdata_q <= '0;
      data_err_q   <= 1'b0;
    end else begin
      data_state_q <= data_state_d;
      data_rdata_q <= data_rdata_d;
      data_err_q   <= data_err_d;
    end
  end

  assign o_inst_resp_data  = inst_data_q;
  assign o_inst_resp_err   = inst_err_q;
  assign o_data_resp_rdata = data_rdata_q;
  assign o_data_resp_err   = data_err_q;

endmodule

// File: tb/tb_ram_pipe.sv
// tb_ram_pipe: directed and random stimulus for ram_pipe, checked against a
// word-array reference model of the memory and per-port response slots.
module tb_ram_pipe;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DL = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_inst_req_valid;
  logic          o_inst_req_ready;
  logic [AW-1:0] i_inst_req_addr;
  logic          o_inst_resp_valid;
  logic          i_inst_resp_ready;
  logic [DW-1:0] o_inst_resp_data;
  logic          o_inst_resp_err;
  logic          i_data_req_valid;
  logic          o_data_req_ready;
  logic          i_data_req_wen;
  logic [AW-1:0] i_data_req_addr;
  logic [DW-1:0] i_data_req_wdata;
  logic [3:0]    i_data_req_mask;
  logic          o_data_resp_valid;
  logic          i_data_resp_ready;
  logic [DW-1:0] o_data_resp_rdata;
  logic          o_data_resp_err;

  always #5 clk = ~clk;

  ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .i_sys_clk         (clk),
    .i_sys_rst_n       (rst_n),
    .i_inst_req_valid  (i_inst_req_valid),
    .o_inst_req_ready  (o_inst_req_ready),
    .i_inst_req_addr   (i_inst_req_addr),
    .o_inst_resp_valid (o_inst_resp_valid),
    .i_inst_resp_ready (i_inst_resp_ready),
    .o_inst_resp_data  (o_inst_resp_data),
    .o_inst_resp_err   (o_inst_resp_err),
    .i_data_req_valid  (i_data_req_valid),
    .o_data_req_ready  (o_data_req_ready),
    .i_data_req_wen    (i_data_req_wen),
    .i_data_req_addr   (i_data_req_addr),
    .i_data_req_wdata  (i_data_req_wdata),
    .i_data_req_mask   (i_data_req_mask),
    .o_data_resp_valid (o_data_resp_valid),
    .i_data_resp_ready (i_data_resp_ready),
    .o_data_resp_rdata (o_data_resp_rdata),
    .o_data_resp_err   (o_data_resp_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word array plus one response slot per port.
  logic [31:0] mdl [int];
  logic        mi_v, md_v;
  logic [31:0] mi_d, md_d;
  logic        mi_e, md_e;
  logic        last_iacc;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'h0001_0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("inst_resp_valid", 32'(o_inst_resp_valid), 32'(mi_v));
    check("data_resp_valid", 32'(o_data_resp_valid), 32'(md_v));
    if (mi_v) begin
      check("inst_resp_data", o_inst_resp_data, mi_d);
      check("inst_resp_err", 32'(o_inst_resp_err), 32'(mi_e));
    end
    if (md_v) begin
      check("data_resp_rdata", o_data_resp_rdata, md_d);
      check("data_resp_err", 32'(o_data_resp_err), 32'(md_e));
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic iv, input logic [31:0] ia, input logic irr,
                       input logic dv, input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] dm, input logic drr);
    logic        iacc, dacc, nie, nde;
    logic [31:0] nid, ndd, w;
    int          k;
    i_inst_req_valid  = iv;
    i_inst_req_addr   = ia;
    i_inst_resp_ready = irr;
    i_data_req_valid  = dv;
    i_data_req_wen    = dw;
    i_data_req_addr   = da;
    i_data_req_wdata  = dwd;
    i_data_req_mask   = dm;
    i_data_resp_ready = drr;
    #1;
    check("inst_req_ready", 32'(o_inst_req_ready), 32'(!mi_v || irr));
    check("data_req_ready", 32'(o_data_req_ready), 32'(!md_v || drr));
    iacc = iv && (!mi_v || irr);
    dacc = dv && (!md_v || drr);
    // Data port first: its read sees the old word, its write then lands
    // before the instruction read, giving write-first on a shared word.
    nde = bad_addr(da);
    ndd = 32'h0;
    if (dacc && !nde) begin
      k = int'(da >> 2);
      if (!dw) begin
        ndd = mdl[k];
      end else begin
        w = mdl.exists(k) ? mdl[k] : 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (dm[b]) w[8*b +: 8] = dwd[8*b +: 8];
        end
        mdl[k] = w;
      end
    end
    nie = bad_addr(ia);
    nid = (iacc && !nie) ? mdl[int'(ia >> 2)] : 32'h0;
    if (iacc || dacc)
      $display("txn t=%0t inst_acc=%0b addr=%h | data_acc=%0b wen=%0b addr=%h wdata=%h mask=%h",
               $time, iacc, ia, dacc, dw, da, dwd, dm);
    @(posedge clk);
    #1;
    if (iacc) begin
      mi_v = 1'b1; mi_d = nid; mi_e = nie;
    end else if (irr) begin
      mi_v = 1'b0;
    end
    if (dacc) begin
      md_v = 1'b1; md_d = ndd; md_e = nde;
    end else if (drr) begin
      md_v = 1'b0;
    end
    last_iacc = iacc;
    check_outputs();
  endtask

  initial begin
    logic [31:0] q[$];
    rst_n = 1'b0;
    i_inst_req_valid = 0; i_inst_req_addr = 0; i_inst_resp_ready = 0;
    i_data_req_valid = 0; i_data_req_wen = 0; i_data_req_addr = 0;
    i_data_req_wdata = 0; i_data_req_mask = 0; i_data_resp_ready = 0;
    mi_v = 0; md_v = 0; mi_d = 0; md_d = 0; mi_e = 0; md_e = 0; last_iacc = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst_valid", 32'(o_inst_resp_valid), 32'h0);
    check("rst_data_valid", 32'(o_data_resp_valid), 32'h0);
    check("rst_inst_data", o_inst_resp_data, 32'h0);
    check("rst_data_rdata", o_data_resp_rdata, 32'h0);
    check("rst_inst_err", 32'(o_inst_resp_err), 32'h0);
    check("rst_data_err", 32'(o_data_resp_err), 32'h0);
    rst_n = 1'b1;

    // Initialise words 0..15 with random data (first edge after release).
    for (int i = 0; i < 16; i++)
      cycle(0, 0, 1, 1, 1, 32'(i * 4), $urandom, 4'hF, 1);

    // Full write then read on both ports.
    cycle(0, 0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 1);
    cycle(1, 32'h100, 1, 1, 0, 32'h100, 0, 0, 1);
    check("vec1_inst", o_inst_resp_data, 32'hDEADBEEF);
    check("vec1_data", o_data_resp_rdata, 32'hDEADBEEF);

    // Partial mask overwrite.
    cycle(0, 0, 1, 1, 1, 32'h100, 32'h11223344, 4'h5, 1);
    cycle(0, 0, 1, 1, 0, 32'h100, 0, 0, 1);
    check("vec2_data", o_data_resp_rdata, 32'hDE22BE44);

    // Misaligned and out-of-range reads, then an untouched word.
    cycle(0, 0, 1, 1, 0, 32'h102, 0, 0, 1);
    check("vec3_mis_err", 32'(o_data_resp_err), 32'h1);
    cycle(0, 0, 1, 1, 0, 32'h10000, 0, 0, 1);
    check("vec3_oor_err", 32'(o_data_resp_err), 32'h1);
    check("vec3_oor_data", o_data_resp_rdata, 32'h0);
    cycle(1, 32'h10004, 1, 1, 1, 32'h10004, 32'hFFFFFFFF, 4'hF, 1);
    cycle(0, 0, 1, 1, 0, 32'h0, 0, 0, 1);

    // Stalled instruction stream: hold ready low for three cycles.
    q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    for (int c = 0; c < 12 && q.size() > 0; c++) begin
      cycle(1, q[0], (c >= 1 && c <= 3) ? 1'b0 : 1'b1, 0, 0, 0, 0, 0, 1);
      if (last_iacc) void'(q.pop_front());
    end
    check("stream_drained", 32'(q.size()), 32'h0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);

    // Same-edge write and instruction read to one word.
    cycle(0, 0, 1, 1, 1, 32'h200, 32'h0, 4'hF, 1);
    cycle(1, 32'h200, 1, 1, 1, 32'h200, 32'hAABBCCDD, 4'h3, 1);
    check("vec5_inst", o_inst_resp_data, 32'h0000CCDD);

    // Random traffic over the initialised words.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ia, da;
      int          r;
      r  = int'($urandom_range(0, 9));
      ia = (r == 0) ? 32'h10000 + ($urandom_range(0, 15) << 2) :
           (r == 1) ? ($urandom_range(0, 15) << 2) + 32'd2 : ($urandom_range(0, 15) << 2);
      r  = int'($urandom_range(0, 9));
      da = (r == 0) ? 32'h20000 + ($urandom_range(0, 15) << 2) :
           (r == 1) ? ($urandom_range(0, 15) << 2) + 32'd1 : ($urandom_range(0, 15) << 2);
      cycle(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da, $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);

    // Zero-mask write leaves the word alone.
    cycle(0, 0, 1, 1, 1, 32'h100, 32'hFFFFFFFF, 4'h0, 1);

    // Reset while responses are pending; storage must survive.
    cycle(1, 32'h100, 1, 1, 0, 32'h100, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    mi_v = 0; md_v = 0; mi_d = 0; md_d = 0; mi_e = 0; md_e = 0;
    check("arst_inst_valid", 32'(o_inst_resp_valid), 32'h0);
    check("arst_data_valid", 32'(o_data_resp_valid), 32'h0);
    check("arst_inst_data", o_inst_resp_data, 32'h0);
    check("arst_data_rdata", o_data_resp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1, 32'h100, 1, 1, 0, 32'h100, 0, 0, 1);
    check("vec6_data", o_data_resp_rdata, 32'hDE22BE44);
    check("vec6_inst", o_inst_resp_data, 32'hDE22BE44);
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_pipe.md
RAM_PIPE -- requirements
Module: ram_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter DEPTH_LOG2, default 14, log2 of word count; OFF = log2(DATA_WIDTH/8).
REQ-004 i_sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_inst_req_valid / o_inst_req_ready  in/out  1  instruction-port read request handshake.
REQ-007 i_inst_req_addr  in  ADDR_WIDTH  instruction byte address.
REQ-008 o_inst_resp_valid / i_inst_resp_ready  out/in  1  instruction response handshake.
REQ-009 o_inst_resp_data  out  DATA_WIDTH  read word; o_inst_resp_err  out  1  address error.
REQ-010 i_data_req_valid / o_data_req_ready  in/out  1  data-port request handshake.
REQ-011 i_data_req_wen  in  1  1 = write, 0 = read; i_data_req_addr  in  ADDR_WIDTH  byte address.
REQ-012 i_data_req_wdata  in  DATA_WIDTH; i_data_req_mask  in  DATA_WIDTH/8  byte-lane write enables.
REQ-013 o_data_resp_valid / i_data_resp_ready  out/in  1; o_data_resp_rdata  out  DATA_WIDTH; o_data_resp_err  out  1.

Function
REQ-014 Storage SHALL be 2**DEPTH_LOG2 words of DATA_WIDTH; word index = addr[DEPTH_LOG2+OFF-1 : OFF].
REQ-015 Request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-016 Each port SHALL have two states: IDLE (resp_valid=0) and RESP (resp_valid=1).
REQ-017 req_ready SHALL equal !resp_valid || resp_ready, combinationally, per port.
REQ-018 Accepted request SHALL produce resp_valid=1 on the next cycle (latency 1); state -> RESP.
REQ-019 In RESP, resp_ready=1 with no new accept -> IDLE; resp_ready=1 with new accept -> stay RESP with new data (back-to-back, one per cycle).
REQ-020 In RESP with resp_ready=0, resp data/err SHALL hold stable and req_ready SHALL be 0.
REQ-021 Address error: addr[OFF-1:0] != 0 (misaligned) or any addr bit at or above DEPTH_LOG2+OFF nonzero (out of range).
REQ-022 Errored request SHALL respond with err=1, data 0, and SHALL NOT modify storage.
REQ-023 Data-port write SHALL update only bytes whose mask bit is 1 at the accepting edge; its response has rdata=0, err per REQ-021.
REQ-024 Write with mask all-zero SHALL respond normally and leave storage unchanged.
REQ-025 Read response SHALL return the word as stored after any write accepted in an earlier cycle.
REQ-026 Same-edge collision (data write and instruction read to same word): instruction response SHALL return write-first merged word (masked bytes new, others old).
REQ-027 Response data registers SHALL capture at accept only; no combinational path from memory to outputs.

Reset
REQ-028 While i_sys_rst_n=0: both resp_valid=0, resp data=0, err=0, states IDLE, no write performed.
REQ-029 Reset asserted mid-operation SHALL drop pending responses immediately; storage contents SHALL be preserved (not cleared).
REQ-030 First request SHALL be acceptable on the first rising edge after reset deassertion.

Verification
REQ-031 Write 0xDEADBEEF mask 0xF to 0x100, then read 0x100 on both ports -> both return 0xDEADBEEF, err=0, one cycle after accept.
REQ-032 Write 0x11223344 mask 0x5 over 0xDEADBEEF at 0x100 -> read returns 0xDE22BE44.
REQ-033 Data read 0x102 (misaligned) and 0x10000 (DEPTH_LOG2=14, 32-bit) -> err=1, data 0; follow-up read of 0x0 unchanged.
REQ-034 Hold i_inst_resp_ready=0 for 3 cycles with valid requests streaming -> resp stable, req_ready=0; release -> one response per cycle, order preserved, no loss.
REQ-035 Same-edge data write 0xAABBCCDD mask 0x3 and inst read to word holding 0x00000000 -> inst response 0x0000CCDD.
REQ-036 Assert reset while RESP pending -> resp_valid=0 asynchronously; after release, prior-written word still reads back its value.
